// File: rtl/present_seq.sv
// -----------------------------------------------------------------------------
// present_seq
//
// Bus-master sequencer for the PRESENT wrapper's 4-bit-address register port.
// Whole 64-bit blocks arrive on a valid/ready stream. The sequencer writes the
// key and direction only when they differ from what the wrapper already holds.
// It then writes the block, starts the core and polls for done. Finally it
// reads both result words and offers the 64-bit result on a second
// valid/ready stream.
//
// Ports
//   clk          clock, all logic on the rising edge
//   iReset       synchronous active-high reset (shared with the wrapper)
//   iKey         80-bit key, captured on iKeyLoad while oKeyReady=1
//   iKeyLoad     key load pulse
//   oKeyReady    high while idle
//   iBlkValid    block stream valid
//   oBlkReady    block stream ready
//   iBlk         64-bit block
//   iDecrypt     direction sampled with the block (1=decrypt)
//   oResValid    result stream valid
//   iResReady    result stream ready
//   oRes         64-bit result {hi,lo}
//   oTimeout     sticky poll-timeout flag
//   oBusy        high whenever the sequencer is not idle
//   oChipselect  register bus select
//   oWriteRead   1=write, 0=read
//   oAddress     register address
//   oWdat        register write data
//   iRdat        register read data, valid the cycle after a read request
//
// Parameter
//   MAX_POLLS    done-polls per block before the block is dropped
//
// Optional feature (macro PRESENT_SEQ_TIMEOUT_EN)
//   Defined:   polling stops after MAX_POLLS done-polls without an accepted
//              done; the block is dropped and oTimeout is set.
//   Undefined: polling is unbounded, oTimeout is tied low and no poll counter
//              is built.
// -----------------------------------------------------------------------------
module present_seq #(
  parameter int MAX_POLLS = 255
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic [79:0] iKey,
  input  logic        iKeyLoad,
  output logic        oKeyReady,
  input  logic        iBlkValid,
  output logic        oBlkReady,
  input  logic [63:0] iBlk,
  input  logic        iDecrypt,
  output logic        oResValid,
  input  logic        iResReady,
  output logic [63:0] oRes,
  output logic        oTimeout,
  output logic        oBusy,
  output logic        oChipselect,
  output logic        oWriteRead,
  output logic [3:0]  oAddress,
  output logic [31:0] oWdat,
  input  logic [31:0] iRdat
);

  typedef enum logic [3:0] {
    IDLE,
    WKEY1,
    WKEY2,
    WKEY3,
    WCTRL,
    WDAT_H,
    WDAT_L,
    START,
    POLL_REQ,
    POLL_CHK,
    RD_H,
    RD_L,
    RD_CAP,
    OUT
  } state_t;

  localparam logic [3:0] ADDR_START = 4'd0;
  localparam logic [3:0] ADDR_KEY1  = 4'd1;
  localparam logic [3:0] ADDR_KEY2  = 4'd2;
  localparam logic [3:0] ADDR_KEY3  = 4'd3;
  localparam logic [3:0] ADDR_DATH  = 4'd4;
  localparam logic [3:0] ADDR_DATL  = 4'd5;
  localparam logic [3:0] ADDR_RESH  = 4'd6;
  localparam logic [3:0] ADDR_RESL  = 4'd7;
  localparam logic [3:0] ADDR_CTRL  = 4'd8;

  // A zero poll budget has no meaning in either build.
  if (MAX_POLLS < 1) begin : gMaxPollsInvalid
    $error("present_seq: MAX_POLLS must be at least 1");
  end

  state_t      state_q, state_d;
  logic [79:0] keySh_q, keySh_d;
  logic        keyDirty_q, keyDirty_d;
  logic        dirSh_q, dirSh_d;
  logic [63:0] blk_q, blk_d;
  logic        blkDir_q, blkDir_d;
  logic [63:0] res_q, res_d;
  logic        seenLow_q, seenLow_d;

  logic        blkReady_q, blkReady_d;
  logic        keyReady_q, keyReady_d;
  logic        resValid_q, resValid_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic        wr_q, wr_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;

`ifdef PRESENT_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_POLLS + 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(MAX_POLLS - 1);
  localparam logic [CNT_W-1:0] POLL_MAX  = CNT_W'(MAX_POLLS);

  logic [CNT_W-1:0] pollCnt_q, pollCnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Next-state logic. The shadow registers mirror what the wrapper holds, so
  // the key and direction are written only when they actually change. A key
  // loaded in the same cycle as a block is used for that block. A done bit is
  // trusted only after a low poll, because the wrapper may still report the
  // previous block's done right after START.
  always_comb begin
    state_d    = state_q;
    keySh_d    = keySh_q;
    keyDirty_d = keyDirty_q;
    dirSh_d    = dirSh_q;
    blk_d      = blk_q;
    blkDir_d   = blkDir_q;
    res_d      = res_q;
    seenLow_d  = seenLow_q;
`ifdef PRESENT_SEQ_TIMEOUT_EN
    pollCnt_d  = pollCnt_q;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (iKeyLoad) begin
          keySh_d    = iKey;
          keyDirty_d = 1'b1;
        end
        if (iBlkValid) begin
          blk_d    = iBlk;
          blkDir_d = iDecrypt;
          if (keyDirty_q || iKeyLoad) begin
            state_d = WKEY1;
          end else if (iDecrypt != dirSh_q) begin
            state_d = WCTRL;
          end else begin
            state_d = WDAT_H;
          end
        end
      end
      WKEY1: state_d = WKEY2;
      WKEY2: state_d = WKEY3;
      WKEY3: begin
        keyDirty_d = 1'b0;
        state_d    = (blkDir_q != dirSh_q) ? WCTRL : WDAT_H;
      end
      WCTRL: begin
        dirSh_d = blkDir_q;
        state_d = WDAT_H;
      end
      WDAT_H: state_d = WDAT_L;
      WDAT_L: state_d = START;
      START: begin
        seenLow_d = 1'b0;
`ifdef PRESENT_SEQ_TIMEOUT_EN
        pollCnt_d = '0;
`endif
        state_d   = POLL_REQ;
      end
      POLL_REQ: state_d = POLL_CHK;
      POLL_CHK: begin
        if (iRdat[0] && seenLow_q) begin
          state_d = RD_H;
        end else begin
          if (!iRdat[0]) begin
            seenLow_d = 1'b1;
          end
          state_d = POLL_REQ;
`ifdef PRESENT_SEQ_TIMEOUT_EN
          if (pollCnt_q == POLL_LAST) begin
            state_d    = IDLE;
            timeout_d  = 1'b1;
            keyDirty_d = 1'b1;
          end
`endif
        end
`ifdef PRESENT_SEQ_TIMEOUT_EN
        if (pollCnt_q != POLL_MAX) begin
          pollCnt_d = pollCnt_q + 1'b1;
        end
`endif
      end
      RD_H: state_d = RD_L;
      RD_L: begin
        res_d[63:32] = iRdat;
        state_d      = RD_CAP;
      end
      RD_CAP: begin
        res_d[31:0] = iRdat;
        state_d     = OUT;
      end
      OUT: begin
        if (iResReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. It is taken from the next state and next shadow values and
  // registered below. Each output therefore matches a Moore decode of the
  // current state, with no path from inputs to outputs.
  always_comb begin
    blkReady_d = (state_d == IDLE);
    keyReady_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    resValid_d = (state_d == OUT);
    cs_d       = 1'b0;
    wr_d       = 1'b0;
    addr_d     = 4'h0;
    wdat_d     = 32'h0;

    case (state_d)
      WKEY1: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_KEY1;
        wdat_d = keySh_d[79:48];
      end
      WKEY2: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_KEY2;
        wdat_d = keySh_d[47:16];
      end
      WKEY3: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_KEY3;
        wdat_d = {16'h0, keySh_d[15:0]};
      end
      WCTRL: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_CTRL;
        wdat_d = {31'h0, blkDir_d};
      end
      WDAT_H: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_DATH;
        wdat_d = blk_d[63:32];
      end
      WDAT_L: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_DATL;
        wdat_d = blk_d[31:0];
      end
      START: begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = ADDR_START;
        wdat_d = 32'h1;
      end
      POLL_REQ: begin
        cs_d   = 1'b1;
        addr_d = ADDR_CTRL;
      end
      RD_H: begin
        cs_d   = 1'b1;
        addr_d = ADDR_RESH;
      end
      RD_L: begin
        cs_d   = 1'b1;
        addr_d = ADDR_RESL;
      end
      default: begin
      end
    endcase
  end

  // State, shadow and output registers. Reset matches the wrapper's own
  // post-reset contents, which is why the key and direction shadows start at
  // zero and clean.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q    <= IDLE;
      keySh_q    <= '0;
      keyDirty_q <= 1'b0;
      dirSh_q    <= 1'b0;
      blk_q      <= '0;
      blkDir_q   <= 1'b0;
      res_q      <= '0;
      seenLow_q  <= 1'b0;
      blkReady_q <= 1'b1;
      keyReady_q <= 1'b1;
      resValid_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 4'h0;
      wdat_q     <= 32'h0;
`ifdef PRESENT_SEQ_TIMEOUT_EN
      pollCnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      keySh_q    <= keySh_d;
      keyDirty_q <= keyDirty_d;
      dirSh_q    <= dirSh_d;
      blk_q      <= blk_d;
      blkDir_q   <= blkDir_d;
      res_q      <= res_d;
      seenLow_q  <= seenLow_d;
      blkReady_q <= blkReady_d;
      keyReady_q <= keyReady_d;
      resValid_q <= resValid_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
`ifdef PRESENT_SEQ_TIMEOUT_EN
      pollCnt_q  <= pollCnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign oBlkReady   = blkReady_q;
  assign oKeyReady   = keyReady_q;
  assign oResValid   = resValid_q;
  assign oRes        = res_q;
  assign oBusy       = busy_q;
  assign oChipselect = cs_q;
  assign oWriteRead  = wr_q;
  assign oAddress    = addr_q;
  assign oWdat       = wdat_q;

`ifdef PRESENT_SEQ_TIMEOUT_EN
  assign oTimeout = timeout_q;
`else
  assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_present_seq.sv
// -----------------------------------------------------------------------------
// tb_present_seq
//
// Directed bench for present_seq. A behavioural model of the PRESENT wrapper
// register port answers the bus. Its result comes from a table of known
// PRESENT-80 vectors, indexed by the key, block and direction actually written
// over the bus. A bus monitor counts writes and polls per block so that
// redundant or missing register accesses show up.
// -----------------------------------------------------------------------------
module tb_present_seq;

`ifdef PRESENT_SEQ_TIMEOUT_EN
  localparam int MAXP = 4;
`else
  localparam int MAXP = 255;
`endif

  logic        clk = 1'b0;
  logic        iReset;
  logic [79:0] iKey;
  logic        iKeyLoad;
  logic        oKeyReady;
  logic        iBlkValid;
  logic        oBlkReady;
  logic [63:0] iBlk;
  logic        iDecrypt;
  logic        oResValid;
  logic        iResReady;
  logic [63:0] oRes;
  logic        oTimeout;
  logic        oBusy;
  logic        oChipselect;
  logic        oWriteRead;
  logic [3:0]  oAddress;
  logic [31:0] oWdat;
  logic [31:0] iRdat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  present_seq #(.MAX_POLLS(MAXP)) dut (
    .clk         (clk),
    .iReset      (iReset),
    .iKey        (iKey),
    .iKeyLoad    (iKeyLoad),
    .oKeyReady   (oKeyReady),
    .iBlkValid   (iBlkValid),
    .oBlkReady   (oBlkReady),
    .iBlk        (iBlk),
    .iDecrypt    (iDecrypt),
    .oResValid   (oResValid),
    .iResReady   (iResReady),
    .oRes        (oRes),
    .oTimeout    (oTimeout),
    .oBusy       (oBusy),
    .oChipselect (oChipselect),
    .oWriteRead  (oWriteRead),
    .oAddress    (oAddress),
    .oWdat       (oWdat),
    .iRdat       (iRdat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper model: register file, done generator and known-answer results.
  logic [79:0] sKey;
  logic [63:0] sBlk;
  logic        sDir;
  logic [63:0] sRes;
  int          readIdx;
  int          doneAfter = 1;
  bit          staleMode = 1'b0;
  logic        pollDone;

  assign pollDone = (staleMode && readIdx == 0) || (readIdx >= doneAfter);

  function automatic logic [63:0] presentModel(input logic [79:0] k,
                                               input logic [63:0] d,
                                               input logic dec);
    if (!dec && k == 80'h0 && d == 64'h0) return 64'h5579C1387B228445;
    if (!dec && k == {80{1'b1}} && d == 64'h0) return 64'hE72C46C0F5945049;
    if (dec && k == {80{1'b1}} && d == 64'hE72C46C0F5945049) return 64'h0;
    return 64'hBAD0BAD0BAD0BAD0;
  endfunction

  always @(posedge clk) begin
    if (iReset) begin
      sKey    <= '0;
      sBlk    <= '0;
      sDir    <= 1'b0;
      sRes    <= '0;
      readIdx <= 0;
      iRdat   <= '0;
    end else begin
      iRdat <= '0;
      if (oChipselect && oWriteRead) begin
        case (oAddress)
          4'd0: if (oWdat[0]) begin
            sRes    <= presentModel(sKey, sBlk, sDir);
            readIdx <= 0;
          end
          4'd1: sKey[79:48] <= oWdat;
          4'd2: sKey[47:16] <= oWdat;
          4'd3: sKey[15:0]  <= oWdat[15:0];
          4'd4: sBlk[63:32] <= oWdat;
          4'd5: sBlk[31:0]  <= oWdat;
          4'd8: sDir        <= oWdat[0];
          default: begin
          end
        endcase
      end else if (oChipselect) begin
        case (oAddress)
          4'd8: begin
            iRdat   <= {31'h0, pollDone};
            readIdx <= readIdx + 1;
          end
          4'd6: iRdat <= sRes[63:32];
          4'd7: iRdat <= sRes[31:0];
          default: begin
          end
        endcase
      end
    end
  end

  // Bus monitor, sampled mid-cycle.
  int          wrCnt[16];
  int          firstWrAddr;
  int          firstPollCyc;
  int          pollReads;
  int          acceptCyc;
  logic [31:0] lastDirWr;

  always @(negedge clk) begin
    if (!iReset && oChipselect) begin
      if (oWriteRead) begin
        wrCnt[oAddress] = wrCnt[oAddress] + 1;
        if (firstWrAddr < 0) firstWrAddr = int'(oAddress);
        if (oAddress == 4'd8) lastDirWr = oWdat;
      end else if (oAddress == 4'd8) begin
        pollReads = pollReads + 1;
        if (firstPollCyc < 0) firstPollCyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offers one block (optionally with a same-cycle key load) and returns one
  // cycle after the accepting edge. Called just after a rising edge.
  task automatic applyStimulus(input logic [63:0] blk, input logic dec,
                               input logic kl, input logic [79:0] key,
                               input int dAfter, input bit stale);
    for (int i = 0; i < 16; i++) wrCnt[i] = 0;
    firstWrAddr  = -1;
    firstPollCyc = -1;
    pollReads    = 0;
    acceptCyc    = -1;
    lastDirWr    = 32'hFFFF_FFFF;
    doneAfter    = dAfter;
    staleMode    = stale;
    iBlk      = blk;
    iDecrypt  = dec;
    iKeyLoad  = kl;
    iKey      = key;
    iBlkValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (oBlkReady) begin
        acceptCyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    iBlkValid = 1'b0;
    iKeyLoad  = 1'b0;
    if (acceptCyc < 0) checkOutput("acceptTimeout", 64'd0, 64'd1);
  endtask

  task automatic collectResult(input string tag, input logic [63:0] expRes,
                               input int expFirstWr, input int expKeyWr,
                               input int expDirWr, input int expLat,
                               input int expPolls);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (oResValid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({tag, ".valid"}, 64'(found), 64'd1);
    checkOutput({tag, ".res"}, oRes, expRes);
    checkOutput({tag, ".firstWr"}, 64'(firstWrAddr), 64'(expFirstWr));
    checkOutput({tag, ".keyWr"}, 64'(wrCnt[1] + wrCnt[2] + wrCnt[3]),
                64'(expKeyWr));
    checkOutput({tag, ".dirWr"}, 64'(wrCnt[8]), 64'(expDirWr));
    checkOutput({tag, ".dataWr"}, 64'(wrCnt[4] + wrCnt[5] + wrCnt[0]), 64'd3);
    checkOutput({tag, ".pollLat"}, 64'(firstPollCyc - acceptCyc), 64'(expLat));
    checkOutput({tag, ".polls"}, 64'(pollReads), 64'(expPolls));
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".blkReady"}, 64'(oBlkReady), 64'd1);
    checkOutput({tag, ".keyReady"}, 64'(oKeyReady), 64'd1);
    checkOutput({tag, ".resValid"}, 64'(oResValid), 64'd0);
    checkOutput({tag, ".busy"}, 64'(oBusy), 64'd0);
    checkOutput({tag, ".cs"}, 64'(oChipselect), 64'd0);
    checkOutput({tag, ".wr"}, 64'(oWriteRead), 64'd0);
    checkOutput({tag, ".addr"}, 64'(oAddress), 64'd0);
    checkOutput({tag, ".wdat"}, 64'(oWdat), 64'd0);
    checkOutput({tag, ".res"}, oRes, 64'd0);
    checkOutput({tag, ".timeout"}, 64'(oTimeout), 64'd0);
  endtask

  initial begin
    int   hsCyc;
    int   bad;
    bit   found;
    bit   sawValid;
    bit   idleSeen;
    logic [63:0] captured;

    iReset    = 1'b1;
    iKey      = '0;
    iKeyLoad  = 1'b0;
    iBlkValid = 1'b0;
    iBlk      = '0;
    iDecrypt  = 1'b0;
    iResReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    iReset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] clean key/dir, block 0");
    applyStimulus(64'h0, 1'b0, 1'b0, 80'h0, 3, 1'b0);
    collectResult("clean", 64'h5579C1387B228445, 4, 0, 0, 4, 4);

    $display("[TB] key load with block in the same cycle");
    applyStimulus(64'h0, 1'b0, 1'b1, {80{1'b1}}, 1, 1'b0);
    collectResult("keyLoad", 64'hE72C46C0F5945049, 1, 3, 0, 7, 2);

    $display("[TB] repeated block");
    applyStimulus(64'h0, 1'b0, 1'b0, 80'h0, 1, 1'b0);
    collectResult("repeat", 64'hE72C46C0F5945049, 4, 0, 0, 4, 2);

    $display("[TB] decrypt");
    applyStimulus(64'hE72C46C0F5945049, 1'b1, 1'b0, 80'h0, 1, 1'b0);
    collectResult("decrypt", 64'h0, 8, 0, 1, 5, 2);
    checkOutput("decrypt.dirVal", 64'(lastDirWr), 64'd1);

    $display("[TB] result back-pressure");
    iResReady = 1'b0;
    applyStimulus(64'hE72C46C0F5945049, 1'b1, 1'b0, 80'h0, 1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (oResValid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("hold.valid", 64'(found), 64'd1);
    checkOutput("hold.res", oRes, 64'h0);
    captured = oRes;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (oRes !== captured || oResValid !== 1'b1 || oBlkReady !== 1'b0 ||
          oKeyReady !== 1'b0 || oChipselect !== 1'b0 || oBusy !== 1'b1)
        bad = bad + 1;
    end
    checkOutput("hold.stable", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    iResReady = 1'b1;
    @(negedge clk);
    hsCyc = cyc;
    checkOutput("hold.hsValid", 64'(oResValid), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(64'h0, 1'b0, 1'b0, 80'h0, 1, 1'b0);
    checkOutput("b2b.accept", 64'(acceptCyc), 64'(hsCyc + 1));
    collectResult("b2b", 64'hE72C46C0F5945049, 8, 0, 1, 5, 2);
    checkOutput("b2b.dirVal", 64'(lastDirWr), 64'd0);

    $display("[TB] stale done after start");
    applyStimulus(64'h0, 1'b0, 1'b0, 80'h0, 2, 1'b1);
    collectResult("stale", 64'hE72C46C0F5945049, 4, 0, 0, 4, 3);

`ifdef PRESENT_SEQ_TIMEOUT_EN
    $display("[TB] poll timeout");
    applyStimulus(64'h0, 1'b0, 1'b0, 80'h0, 1000, 1'b0);
    sawValid = 1'b0;
    idleSeen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (oResValid) sawValid = 1'b1;
      if (!oBusy) begin
        idleSeen = 1'b1;
        break;
      end
    end
    checkOutput("tmo.idle", 64'(idleSeen), 64'd1);
    checkOutput("tmo.polls", 64'(pollReads), 64'd4);
    checkOutput("tmo.flag", 64'(oTimeout), 64'd1);
    checkOutput("tmo.noResult", 64'(sawValid), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(64'h0, 1'b0, 1'b0, 80'h0, 1, 1'b0);
    collectResult("tmoRecover", 64'hE72C46C0F5945049, 1, 3, 0, 7, 2);
`else
    $display("[TB] long poll");
    sawValid = 1'b0;
    idleSeen = 1'b0;
    applyStimulus(64'h0, 1'b0, 1'b0, 80'h0, 20, 1'b0);
    collectResult("longPoll", 64'hE72C46C0F5945049, 4, 0, 0, 4, 21);
    checkOutput("longPoll.timeout", 64'(oTimeout), 64'd0);
`endif

    $display("[TB] reset during WDAT_L");
    applyStimulus(64'h0123456789ABCDEF, 1'b0, 1'b0, 80'h0, 1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (oChipselect && oWriteRead && oAddress == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rst.sawWdatL", 64'(found), 64'd1);
    iReset = 1'b1;
    @(negedge clk);
    checkResetOutputs("rstMid");
    checkOutput("rstMid.noStart", 64'(wrCnt[0]), 64'd0);
    @(posedge clk);
    #1;
    iReset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(64'h0, 1'b0, 1'b0, 80'h0, 1, 1'b0);
    collectResult("afterRst", 64'h5579C1387B228445, 4, 0, 0, 4, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors = errors + 1;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
